// File: rtl/alu_dut_gen.sv
// Tiny ALU: arithmetic, multiply, guarded load/store and supervisor clear of an internal word memory.
// Latency: 3 edges for single-cycle ops, 2+MUL_LAT for MUL, 2+DEPTH for CLR, 2 for decode errors.
// Backpressure: one op in flight; start is honoured only in IDLE, otherwise dropped (no queueing).
module alu_dut_gen #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic [7:0]            op,
    input  logic                  op_pf,
    input  logic                  sv,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result,
    output logic [7:0]            err,
    output logic                  gp
);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int RES_W   = 2 * DATA_W;
    localparam int CNT_MAX = (DEPTH > MUL_LAT) ? DEPTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE} state_t;
    typedef enum logic [3:0] {
        C_NOP, C_ADD, C_SUB, C_AND, C_XOR, C_MUL, C_ST, C_LD, C_CLR, C_ILL
    } cls_t;

    state_t              state, state_nxt;
    cls_t                cls;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [7:0]          op_q;
    logic                pf_q, sv_q;
    logic [CNT_W-1:0]    cnt, cnt_load;
    logic [7:0]          dec_err;
    logic [RES_W-1:0]    exec_res;
    logic [DATA_W-1:0]   diff;
    logic [CNT_W-1:0]    clr_off;
    logic [ADDR_W-1:0]   mem_addr, clr_addr;
    logic                exec_last;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_comb begin
        cls = C_ILL;
        if (pf_q) begin
            case (op_q)
                8'h00:   cls = C_ST;
                8'h01:   cls = C_LD;
                default: cls = C_ILL;
            endcase
        end else if (!sv_q) begin
            case (op_q)
                8'h00:   cls = C_NOP;
                8'h01:   cls = C_ADD;
                8'h02:   cls = C_SUB;
                8'h03:   cls = C_AND;
                8'h04:   cls = C_XOR;
                8'h05:   cls = C_MUL;
                default: cls = C_ILL;
            endcase
        end else if (op_q == 8'h0A) begin
            cls = C_CLR;
        end
    end

    // Range check uses the full operand width so high garbage bits cannot alias into memory.
    always_comb begin
        dec_err = 8'h00;
        if (cls == C_ILL)
            dec_err = 8'h01;
        else if (cls == C_ST || cls == C_LD) begin
            if (a_q >= DATA_W'(DEPTH))
                dec_err = 8'h02;
            else if (a_q >= DATA_W'(DEPTH / 2) && !sv_q)
                dec_err = 8'h03;
        end
    end

    always_comb begin
        cnt_load = CNT_W'(1);
        if (cls == C_CLR)      cnt_load = CNT_W'(DEPTH);
        else if (cls == C_MUL) cnt_load = CNT_W'(MUL_LAT);
    end

    assign mem_addr  = a_q[ADDR_W-1:0];
    assign clr_off   = CNT_W'(DEPTH) - cnt;
    assign clr_addr  = clr_off[ADDR_W-1:0];
    assign diff      = a_q - b_q;
    assign exec_last = (state == S_EXEC) && (cnt == CNT_W'(1));

    always_comb begin
        exec_res = '0;
        case (cls)
            C_ADD:   exec_res = RES_W'(a_q) + RES_W'(b_q);
            C_SUB:   exec_res = RES_W'(diff);
            C_AND:   exec_res = RES_W'(a_q & b_q);
            C_XOR:   exec_res = RES_W'(a_q ^ b_q);
            C_MUL:   exec_res = RES_W'(a_q) * RES_W'(b_q);
            C_ST:    exec_res = RES_W'(b_q);
            C_LD:    exec_res = RES_W'(mem[mem_addr]);
            default: exec_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (dec_err != 8'h00) ? S_DONE : S_EXEC;
            S_EXEC:   if (exec_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_DECODE) || (state == S_EXEC);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            pf_q   <= 1'b0;
            sv_q   <= 1'b0;
            cnt    <= '0;
            result <= '0;
            err    <= '0;
            gp     <= 1'b0;
        end else begin
            gp <= 1'b0;
            if (state == S_IDLE && start) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
                pf_q <= op_pf;
                sv_q <= sv;
            end
            if (state == S_DECODE) begin
                cnt <= cnt_load;
                if (dec_err != 8'h00) begin
                    result <= '0;
                    err    <= dec_err;
                    gp     <= (dec_err == 8'h03);
                end
            end
            if (state == S_EXEC) begin
                cnt <= cnt - CNT_W'(1);
                if (exec_last) begin
                    result <= exec_res;
                    err    <= 8'h00;
                end
            end
        end
    end

    // Memory has no reset; writes are suppressed on a reset edge so an abort never lands a word.
    always_ff @(posedge clk) begin
        if (!reset && state == S_EXEC) begin
            if (cls == C_ST)
                mem[mem_addr] <= b_q;
            else if (cls == C_CLR)
                mem[clr_addr] <= '0;
        end
    end
endmodule

// File: tb/tb_alu_dut_gen.sv
// Bench for alu_dut_gen: vector table plus hand sequences for busy-start, clear and reset abort.
module tb_alu_dut_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [7:0]  op;
    logic        op_pf, sv, start;
    logic        busy, done, gp;
    logic [63:0] result;
    logic [7:0]  err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  op;
        logic        pf;
        logic        sv;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic [7:0]  err;
        logic        gp;
        int          lat;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    alu_dut_gen #(.DATA_W(32), .DEPTH(16), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .op_pf(op_pf), .sv(sv),
        .start(start), .busy(busy), .done(done), .result(result), .err(err), .gp(gp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] o, input logic p, input logic s,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] r, input logic [7:0] e, input logic g,
                                input int l);
        vec_t v;
        v.op = o; v.pf = p; v.sv = s; v.a = a; v.b = b;
        v.res = r; v.err = e; v.gp = g; v.lat = l;
        return v;
    endfunction

    // Called #1 after an edge with the DUT in IDLE; returns #1 after the capturing edge.
    task automatic issue(input vec_t v);
        A = v.a; B = v.b; op = v.op; op_pf = v.pf; sv = v.sv; start = 1'b1;
        exp_q.push_back(v);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_capture", {63'd0, busy}, 64'd1);
    endtask

    task automatic complete(input int lat0);
        int   lat;
        vec_t e;
        lat = lat0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow: done with no expected entry");
            return;
        end
        e = exp_q.pop_front();
        check("latency", 64'(lat), 64'(e.lat));
        check("result", result, e.res);
        check("err", {56'd0, err}, {56'd0, e.err});
        check("gp", {63'd0, gp}, {63'd0, e.gp});
        check("busy_in_done", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("gp_cleared", {63'd0, gp}, 64'd0);
        check("result_held", result, e.res);
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    task automatic run(input vec_t v);
        issue(v);
        complete(1);
    endtask

    initial begin
        int nd;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; op = '0; op_pf = 1'b0; sv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_err", {56'd0, err}, 64'd0);
        check("rst_gp", {63'd0, gp}, 64'd0);

        // Start coincident with reset must not be captured.
        op = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_start_ignored", {63'd0, busy}, 64'd0);

        tbl.push_back(mk(8'h01, 0, 0, 32'hFFFF_FFFF, 32'h1,         64'h1_0000_0000,        8'h00, 0, 3));
        tbl.push_back(mk(8'h02, 0, 0, 32'h5,         32'h7,         64'h0000_0000_FFFF_FFFE, 8'h00, 0, 3));
        tbl.push_back(mk(8'h03, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h00F0_00F0,          8'h00, 0, 3));
        tbl.push_back(mk(8'h04, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'hFF00_FF00,          8'h00, 0, 3));
        tbl.push_back(mk(8'h00, 0, 0, 32'h5,         32'h6,         64'h0,                  8'h00, 0, 3));
        tbl.push_back(mk(8'h05, 0, 0, 32'h1234_5678, 32'h10,        64'h1_2345_6780,        8'h00, 0, 5));
        tbl.push_back(mk(8'h05, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8'h00, 0, 5));
        tbl.push_back(mk(8'h00, 1, 0, 32'h3,         32'hCAFE,      64'hCAFE,               8'h00, 0, 3));
        tbl.push_back(mk(8'h01, 1, 0, 32'h3,         32'h0,         64'hCAFE,               8'h00, 0, 3));
        tbl.push_back(mk(8'h01, 1, 0, 32'd16,        32'h0,         64'h0,                  8'h02, 0, 2));
        tbl.push_back(mk(8'h00, 1, 1, 32'h9,         32'h5555,      64'h5555,               8'h00, 0, 3));
        tbl.push_back(mk(8'h00, 1, 0, 32'h9,         32'h1234,      64'h0,                  8'h03, 1, 2));
        tbl.push_back(mk(8'h01, 1, 1, 32'h9,         32'h0,         64'h5555,               8'h00, 0, 3));
        tbl.push_back(mk(8'h00, 1, 1, 32'h9,         32'h1234,      64'h1234,               8'h00, 0, 3));
        tbl.push_back(mk(8'h01, 1, 1, 32'h9,         32'h0,         64'h1234,               8'h00, 0, 3));
        tbl.push_back(mk(8'h01, 1, 0, 32'h9,         32'h0,         64'h0,                  8'h03, 1, 2));
        tbl.push_back(mk(8'hFF, 0, 0, 32'h1,         32'h2,         64'h0,                  8'h01, 0, 2));
        tbl.push_back(mk(8'h01, 0, 1, 32'h1,         32'h2,         64'h0,                  8'h01, 0, 2));
        tbl.push_back(mk(8'h00, 1, 1, 32'hFFFF_0003, 32'h2,         64'h0,                  8'h02, 0, 2));
        tbl.push_back(mk(8'h02, 1, 1, 32'h1,         32'h2,         64'h0,                  8'h01, 0, 2));
        tbl.push_back(mk(8'h0A, 0, 0, 32'h0,         32'h0,         64'h0,                  8'h01, 0, 2));
        tbl.push_back(mk(8'h0A, 0, 1, 32'h0,         32'h0,         64'h0,                  8'h00, 0, 18));
        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        for (int i = 0; i < 16; i++)
            run(mk(8'h01, 1, 1, 32'(i), 32'h0, 64'h0, 8'h00, 0, 3));

        // A second start while the multiply is busy must be dropped.
        issue(mk(8'h05, 0, 0, 32'h1234_5678, 32'h10, 64'h1_2345_6780, 8'h00, 0, 5));
        A = 32'h1; B = 32'h1; op = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        complete(2);
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("no_extra_done", 64'(nd), 64'd0);

        // Reset in the middle of CLR: words 0..3 are cleared, the rest keep their data.
        run(mk(8'h00, 1, 1, 32'd10, 32'hABCD, 64'hABCD, 8'h00, 0, 3));
        run(mk(8'h00, 1, 1, 32'd2,  32'h7777, 64'h7777, 8'h00, 0, 3));
        issue(mk(8'h0A, 0, 1, 32'h0, 32'h0, 64'h0, 8'h00, 0, 18));
        nd = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(exp_q.pop_front());
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_err", {56'd0, err}, 64'd0);
        check("abort_gp", {63'd0, gp}, 64'd0);
        repeat (25) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        for (int i = 0; i < 4; i++)
            run(mk(8'h01, 1, 1, 32'(i), 32'h0, 64'h0, 8'h00, 0, 3));
        run(mk(8'h01, 1, 1, 32'd10, 32'h0, 64'hABCD, 8'h00, 0, 3));

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_dut_gen.md
# alu_dut_gen

Parametrised second-generation tiny-ALU device: accepts one operation per start/done handshake, decodes the opcode/prefix/supervisor triple, then executes an arithmetic operation, a load/store against an internal word memory, or a supervisor-only memory clear. It generalises the first-generation device in data width and memory depth. It adds a multi-cycle multiplier, a protected upper memory region with general-protection faulting, a busy indicator, and encoded error reporting. It sits between the bench/host driver and nothing else; the memory is internal.

## Interface
- DATA_W, 32, operand width; result is 2*DATA_W
- DEPTH, 16, memory words (power of two, >=4); ADDR_W = clog2(DEPTH)
- MUL_LAT, 3, multiply execute cycles (>=1)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- A  in  DATA_W  operand A / memory address
- B  in  DATA_W  operand B / store data
- op  in  8  opcode
- op_pf  in  1  opcode prefix (memory class)
- sv  in  1  supervisor mode
- start  in  1  request; sampled only in IDLE
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- result  out  2*DATA_W  operation result, held until next completion
- err  out  8  error code, held with result
- gp  out  1  protection fault, pulses with done

## Operation
- States: IDLE, DECODE, EXEC, DONE. IDLE+start captures A, B, op, op_pf, sv and goes to DECODE. start outside IDLE is ignored (no queueing).
- DECODE checks legality, address range and protection. If any check fails, it goes straight to DONE with the error; otherwise it goes to EXEC.
- EXEC runs a down-counter loaded per class (1, MUL_LAT or DEPTH) and goes to DONE when the counter reaches zero. DONE pulses done and returns to IDLE.
- Opcode map (pf, sv, op); all other combinations are illegal, err=8'h01:
  - 0,0,00 NOP: result 0.
  - 0,0,01 ADD: result = zero-extended A+B; carry lands in bit DATA_W.
  - 0,0,02 SUB: result[DATA_W-1:0] = (A-B) mod 2^DATA_W; upper half 0.
  - 0,0,03 AND and 0,0,04 XOR: bitwise; upper half 0.
  - 0,0,05 MUL: unsigned full-width A*B; occupies EXEC for MUL_LAT cycles.
  - 1,x,00 STORE: mem[A]=B; result={0,B}.
  - 1,x,01 LOAD: result={0,mem[A]}.
  - 0,1,0A CLR: writes 0 to every word, one per cycle, address 0 upward, for DEPTH cycles; result 0.
- Memory checks, in priority order:
  - A >= DEPTH (full-width compare): err=8'h02; no access.
  - A >= DEPTH/2 with sv=0: err=8'h03 and gp=1; no write.
- err=8'h00 on success. result is 0 on any error.
- Memory contents are not reset; CLR is the defined initialiser.

## Timing
- Reset: state IDLE; busy, done, gp = 0; result = 0; err = 0; EXEC counter = 0.
- Latency is counted as clock edges from the edge that samples start to the edge after which done is high:
  - single-cycle ALU and memory ops: 3
  - MUL: 2+MUL_LAT
  - CLR: 2+DEPTH
  - decode errors: 2
- busy rises after the capturing edge and falls together with done (done cycle has busy=0). A new start may be presented in the done cycle's following IDLE cycle, i.e. one idle cycle minimum between operations.
- STORE commits on the EXEC edge. A LOAD issued immediately after a STORE to the same address returns the new data.
- result, err and gp update only on the edge entering DONE. gp clears on the next edge; result and err hold.
- reset mid-operation aborts with no done pulse. Memory words already written (partial CLR, committed STORE) remain.
- reset and start asserted together: reset wins and the operation is not captured.

## Test plan
- After reset, ADD A=32'hFFFF_FFFF, B=1 -> done at edge 3, result=64'h1_0000_0000, err=0, gp=0.
- MUL A=32'h1234_5678, B=32'h10 with MUL_LAT=3 -> busy for 5 edges, result=64'h1_2345_6780. A second start pulsed during busy is ignored (exactly one done).
- STORE A=3, B=32'hCAFE, sv=0, then LOAD A=3 -> result=64'hCAFE, err=0. LOAD A=16 (DEPTH=16) -> err=8'h02, done at edge 2.
- STORE A=9, sv=0 -> err=8'h03, gp pulses one cycle, mem[9] unchanged. Repeat with sv=1 -> err=0, and LOAD A=9 returns B.
- op=8'hFF, op_pf=0, sv=0 -> err=8'h01, result=0. Then CLR (sv=1) -> done at edge 18, and LOAD of every address returns 0.
- Assert reset during CLR EXEC at cycle 5 -> no done, outputs zero. Words 0..3 read back 0 and word 10's prior value is retained.
